pipe_hazard_ctrl: RTL and testbench

//  Sequences the five-stage pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB) and the PC.

---
 rtl/mips_pipe_pkg.sv | 28 ++
 rtl/pipe_hazard_ctrl_if.sv | 41 ++++
 rtl/pipe_hazard_ctrl_mdu_seq.sv | 75 +++++++
 rtl/pipe_hazard_ctrl.sv | 123 ++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 162 ++++++++++++++++
 5 files changed

// File: rtl/mips_pipe_pkg.sv
// Shared constants for the pipeline hazard controller: register-specifier
// width, MDU sequencer state encoding and the load-use detection helper.
package mips_pipe_pkg;

  localparam int REG_W = 5;

  localparam logic [1:0] MDU_IDLE = 2'd0;
  localparam logic [1:0] MDU_BUSY = 2'd1;
  localparam logic [1:0] MDU_DONE = 2'd2;

  // A load in EX feeds a source of the ID instruction; $zero never hazards.
  function automatic logic load_use_hit(
    input logic             memread,
    input logic [REG_W-1:0] ex_rt,
    input logic [REG_W-1:0] id_rs,
    input logic [REG_W-1:0] id_rt
  );
    logic hit;
    hit = 1'b0;
    if (memread && (ex_rt != {REG_W{1'b0}})) begin
      hit = (ex_rt == id_rs) || (ex_rt == id_rt);
    end else begin
      hit = 1'b0;
    end
    return hit;
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Bundle between the datapath and the hazard controller: hazard events in,
// pipeline-register enables/flushes and debug status out.
interface pipe_hazard_ctrl_if #(
  parameter int CNT_W = 16
);
  import mips_pipe_pkg::*;

  logic [REG_W-1:0] id_rs;
  logic [REG_W-1:0] id_rt;
  logic             ex_memread;
  logic [REG_W-1:0] ex_rt;
  logic             ex_branch_tkn;
  logic             ex_mdu_start;
  logic             mem_ready;

  logic             pc_en;
  logic             ifid_en;
  logic             ifid_flush;
  logic             idex_en;
  logic             idex_flush;
  logic             exmem_en;
  logic             exmem_flush;
  logic             memwb_en;
  logic             mdu_busy;
  logic [CNT_W-1:0] stall_cycles;

  // Datapath side: reports events, consumes strobes.
  modport master (
    output id_rs, id_rt, ex_memread, ex_rt, ex_branch_tkn, ex_mdu_start, mem_ready,
    input  pc_en, ifid_en, ifid_flush, idex_en, idex_flush,
           exmem_en, exmem_flush, memwb_en, mdu_busy, stall_cycles
  );

  // Controller side.
  modport slave (
    input  id_rs, id_rt, ex_memread, ex_rt, ex_branch_tkn, ex_mdu_start, mem_ready,
    output pc_en, ifid_en, ifid_flush, idex_en, idex_flush,
           exmem_en, exmem_flush, memwb_en, mdu_busy, stall_cycles
  );

endinterface

// File: rtl/pipe_hazard_ctrl_mdu_seq.sv
// MDU sequencer: IDLE -> BUSY -> DONE -> IDLE with a down-counter that keeps
// the multi-cycle op in EX. The start cycle is the first stalled cycle, so
// the counter is loaded with MDU_LAT-2 to hold EX exactly MDU_LAT cycles.
module mdu_seq
  import mips_pipe_pkg::*;
#(
  parameter int MDU_LAT = 32
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic freeze,
  output logic busy,
  output logic done
);

  localparam int CW = (MDU_LAT > 2) ? $clog2(MDU_LAT) : 1;

  logic [1:0]    state_q;
  logic [1:0]    state_d;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Next-state and counter logic; a frozen pipe holds everything.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      MDU_IDLE: begin
        if (start && !freeze) begin
          state_d = MDU_BUSY;
          cnt_d   = CW'(MDU_LAT - 2);
        end else begin
          state_d = MDU_IDLE;
        end
      end
      MDU_BUSY: begin
        if (freeze) begin
          state_d = MDU_BUSY;
        end else if (cnt_q == {CW{1'b0}}) begin
          state_d = MDU_DONE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      MDU_DONE: begin
        // Start is still asserted by the finishing op; never restart here.
        if (freeze) begin
          state_d = MDU_DONE;
        end else begin
          state_d = MDU_IDLE;
        end
      end
      default: begin
        state_d = MDU_IDLE;
        cnt_d   = {CW{1'b0}};
      end
    endcase
  end

  // State registers; reset aborts any op in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= MDU_IDLE;
      cnt_q   <= {CW{1'b0}};
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy = (state_q == MDU_BUSY);
  assign done = (state_q == MDU_DONE);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: owns the PC and all pipeline-register enables
// and flushes. Strobes are combinational from the hazard inputs and the MDU
// state so they act in the same cycle. Also counts stalled cycles.
module pipe_hazard_ctrl
  import mips_pipe_pkg::*;
#(
  parameter int MDU_LAT = 32,
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  pipe_hazard_ctrl_if.slave bus
);

  logic mdu_seq_busy_s;
  logic mdu_seq_done_s;
  logic mdu_stall_s;
  logic load_use_s;
  logic freeze_s;

  logic pc_en_s;
  logic ifid_en_s;
  logic ifid_flush_s;
  logic idex_en_s;
  logic idex_flush_s;
  logic exmem_en_s;
  logic exmem_flush_s;
  logic memwb_en_s;

  logic [CNT_W-1:0] stall_cycles_q;
  logic [CNT_W-1:0] stall_cycles_d;

  assign freeze_s = !bus.mem_ready;

  mdu_seq #(
    .MDU_LAT (MDU_LAT)
  ) u_mdu_seq (
    .clk    (clk),
    .rst    (rst),
    .start  (bus.ex_mdu_start),
    .freeze (freeze_s),
    .busy   (mdu_seq_busy_s),
    .done   (mdu_seq_done_s)
  );

  // The start cycle (sequencer idle, op in EX) already stalls the front end.
  assign mdu_stall_s = mdu_seq_busy_s ||
                       (bus.ex_mdu_start && !mdu_seq_busy_s && !mdu_seq_done_s);
  assign load_use_s  = load_use_hit(bus.ex_memread, bus.ex_rt, bus.id_rs, bus.id_rt);

  // Priority mux: reset, mem wait, MDU, branch, load-use, normal flow.
  always_comb begin
    pc_en_s       = 1'b1;
    ifid_en_s     = 1'b1;
    ifid_flush_s  = 1'b0;
    idex_en_s     = 1'b1;
    idex_flush_s  = 1'b0;
    exmem_en_s    = 1'b1;
    exmem_flush_s = 1'b0;
    memwb_en_s    = 1'b1;
    if (rst) begin
      pc_en_s       = 1'b0;
      ifid_en_s     = 1'b0;
      ifid_flush_s  = 1'b1;
      idex_en_s     = 1'b0;
      idex_flush_s  = 1'b1;
      exmem_en_s    = 1'b0;
      exmem_flush_s = 1'b1;
      memwb_en_s    = 1'b0;
    end else if (freeze_s) begin
      pc_en_s    = 1'b0;
      ifid_en_s  = 1'b0;
      idex_en_s  = 1'b0;
      exmem_en_s = 1'b0;
      memwb_en_s = 1'b0;
    end else if (mdu_stall_s) begin
      pc_en_s       = 1'b0;
      ifid_en_s     = 1'b0;
      idex_en_s     = 1'b0;
      exmem_flush_s = 1'b1;
    end else if (bus.ex_branch_tkn) begin
      // The ID instruction is wrong-path, so this outranks load-use.
      ifid_flush_s = 1'b1;
      idex_flush_s = 1'b1;
    end else if (load_use_s) begin
      pc_en_s      = 1'b0;
      ifid_en_s    = 1'b0;
      idex_flush_s = 1'b1;
    end else begin
      pc_en_s = 1'b1;
    end
  end

  // Saturating count of cycles in which the PC did not advance.
  always_comb begin
    if (!pc_en_s && (stall_cycles_q != {CNT_W{1'b1}})) begin
      stall_cycles_d = stall_cycles_q + CNT_W'(1);
    end else begin
      stall_cycles_d = stall_cycles_q;
    end
  end

  // Stall counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cycles_q <= {CNT_W{1'b0}};
    end else begin
      stall_cycles_q <= stall_cycles_d;
    end
  end

  assign bus.pc_en        = pc_en_s;
  assign bus.ifid_en      = ifid_en_s;
  assign bus.ifid_flush   = ifid_flush_s;
  assign bus.idex_en      = idex_en_s;
  assign bus.idex_flush   = idex_flush_s;
  assign bus.exmem_en     = exmem_en_s;
  assign bus.exmem_flush  = exmem_flush_s;
  assign bus.memwb_en     = memwb_en_s;
  assign bus.mdu_busy     = !rst && (mdu_seq_busy_s || mdu_seq_done_s);
  assign bus.stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl (MDU_LAT=4, CNT_W=4). Each stimulus
// cycle pushes its hand-computed expectation; a negedge monitor pops and
// compares strobes, mdu_busy and stall_cycles.
module tb_pipe_hazard_ctrl;

  localparam int MDU_LAT = 4;
  localparam int CNT_W   = 4;

  // Strobe order: pc_en ifid_en ifid_flush idex_en idex_flush exmem_en exmem_flush memwb_en
  localparam logic [7:0] S_NORM = 8'b1101_0101;
  localparam logic [7:0] S_LU   = 8'b0001_1101;
  localparam logic [7:0] S_BR   = 8'b1111_1101;
  localparam logic [7:0] S_MDU  = 8'b0000_0111;
  localparam logic [7:0] S_FRZ  = 8'b0000_0000;
  localparam logic [7:0] S_RST  = 8'b0010_1010;

  typedef struct {
    int               step;
    logic [8:0]       strb;
    logic [CNT_W-1:0] cnt;
  } exp_t;

  logic clk;
  logic rst;
  int   checks;
  int   failures;
  int   step_no;
  exp_t sb[$];
  exp_t mon_e;
  logic [8:0] got_strb;

  pipe_hazard_ctrl_if #(.CNT_W(CNT_W)) bus ();

  pipe_hazard_ctrl #(
    .MDU_LAT (MDU_LAT),
    .CNT_W   (CNT_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of inputs just after the rising edge and queue its expectation.
  task automatic drv(input logic r, input logic mr, input logic memread,
                     input logic [4:0] ex_rt, input logic [4:0] id_rs, input logic [4:0] id_rt,
                     input logic br, input logic mdu,
                     input logic [7:0] s, input logic busy, input logic [CNT_W-1:0] cnt);
    exp_t e;
    @(posedge clk);
    #1;
    rst               = r;
    bus.mem_ready     = mr;
    bus.ex_memread    = memread;
    bus.ex_rt         = ex_rt;
    bus.id_rs         = id_rs;
    bus.id_rt         = id_rt;
    bus.ex_branch_tkn = br;
    bus.ex_mdu_start  = mdu;
    step_no           = step_no + 1;
    e.step            = step_no;
    e.strb            = {s, busy};
    e.cnt             = cnt;
    sb.push_back(e);
  endtask

  // Monitor: compare the DUT against the oldest queued expectation.
  always @(negedge clk) begin
    if (sb.size() != 0) begin
      mon_e    = sb.pop_front();
      got_strb = {bus.pc_en, bus.ifid_en, bus.ifid_flush, bus.idex_en, bus.idex_flush,
                  bus.exmem_en, bus.exmem_flush, bus.memwb_en, bus.mdu_busy};
      checks = checks + 1;
      if (got_strb !== mon_e.strb) begin
        failures = failures + 1;
        $display("FAIL strobes step %0d: got %b expected %b", mon_e.step, got_strb, mon_e.strb);
      end
      checks = checks + 1;
      if (bus.stall_cycles !== mon_e.cnt) begin
        failures = failures + 1;
        $display("FAIL stall_cycles step %0d: got %0d expected %0d",
                 mon_e.step, bus.stall_cycles, mon_e.cnt);
      end
    end
  end

  initial begin
    checks   = 0;
    failures = 0;
    step_no  = 0;
    rst               = 1'b1;
    bus.mem_ready     = 1'b1;
    bus.ex_memread    = 1'b0;
    bus.ex_rt         = 5'd0;
    bus.id_rs         = 5'd0;
    bus.id_rt         = 5'd0;
    bus.ex_branch_tkn = 1'b0;
    bus.ex_mdu_start  = 1'b0;

    // Reset state
    drv(1'b1, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, S_RST,  1'b0, 4'd0);
    drv(1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, S_NORM, 1'b0, 4'd0);
    // Load-use on rs, then one-cycle recovery
    drv(1'b0, 1'b1, 1'b1, 5'd8, 5'd8, 5'd0, 1'b0, 1'b0, S_LU,   1'b0, 4'd0);
    drv(1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, S_NORM, 1'b0, 4'd1);
    // Load into $zero never stalls
    drv(1'b0, 1'b1, 1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, S_NORM, 1'b0, 4'd1);
    // Branch beats load-use
    drv(1'b0, 1'b1, 1'b1, 5'd8, 5'd0, 5'd8, 1'b1, 1'b0, S_BR,   1'b0, 4'd1);
    // Load-use on rt; then non-matching load
    drv(1'b0, 1'b1, 1'b1, 5'd5, 5'd3, 5'd5, 1'b0, 1'b0, S_LU,   1'b0, 4'd1);
    drv(1'b0, 1'b1, 1'b1, 5'd5, 5'd6, 5'd7, 1'b0, 1'b0, S_NORM, 1'b0, 4'd2);
    // MDU op, start held 5 cycles: 4 stalled cycles, DONE, no restart
    drv(1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, S_MDU,  1'b0, 4'd2);
    drv(1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, S_MDU,  1'b1, 4'd3);
    drv(1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, S_MDU,  1'b1, 4'd4);
    drv(1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, S_MDU,  1'b1, 4'd5);
    drv(1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, S_NORM, 1'b1, 4'd6);
    drv(1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, S_NORM, 1'b0, 4'd6);
    // MDU op with a 3-cycle memory wait in the middle
    drv(1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, S_MDU,  1'b0, 4'd6);
    drv(1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, S_MDU,  1'b1, 4'd7);
    drv(1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, S_FRZ,  1'b1, 4'd8);
    drv(1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, S_FRZ,  1'b1, 4'd9);
    drv(1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, S_FRZ,  1'b1, 4'd10);
    drv(1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, S_MDU,  1'b1, 4'd11);
    drv(1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, S_MDU,  1'b1, 4'd12);
    drv(1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, S_NORM, 1'b1, 4'd13);
    drv(1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, S_NORM, 1'b0, 4'd13);
    // MDU op reaching counter saturation, then reset mid-BUSY
    drv(1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, S_MDU,  1'b0, 4'd13);
    drv(1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, S_MDU,  1'b1, 4'd14);
    drv(1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, S_MDU,  1'b1, 4'd15);
    drv(1'b1, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, S_RST,  1'b0, 4'd0);
    drv(1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, S_NORM, 1'b0, 4'd0);
    // 20-cycle memory wait: counter saturates at 15
    for (int i = 0; i < 20; i++) begin
      drv(1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, S_FRZ, 1'b0,
          (i > 15) ? 4'd15 : CNT_W'(i));
    end
    drv(1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, S_NORM, 1'b0, 4'd15);

    // Let the monitor drain the queue, bounded.
    for (int k = 0; k < 5; k++) begin
      if (sb.size() != 0) begin
        @(negedge clk);
        #1;
      end
    end
    if (sb.size() != 0) begin
      checks   = checks + 1;
      failures = failures + 1;
      $display("FAIL drain: %0d expectations left, expected 0", sb.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
